// File: rtl/s_type.sv
// RV32I store unit: decodes sb/sh/sw, forms the effective address and drives one
// byte-lane-aligned write with a d_we/d_ack handshake, then pulses done (with err).
module s_type #(
  parameter int TIMEOUT = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [6:0]  opcode,
  input  logic [2:0]  funct3,
  input  logic [11:0] imm,
  input  logic [31:0] in1,
  input  logic [31:0] in2,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] d_addr,
  output logic [31:0] d_wdata,
  output logic [3:0]  d_be,
  output logic        d_we,
  input  logic        d_ack,
  output logic [1:0]  dbg_state
);

  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [6:0] OP_STORE = 7'b0100011;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } state_t;

  // Handshake: d_we is held from the first REQ cycle until d_ack is sampled
  // high at a rising edge or TIMEOUT REQ cycles elapse; d_ack is ignored otherwise.
  state_t          r_state;
  state_t          w_next;
  logic [CW-1:0]   r_cnt;
  logic [31:0]     r_addr;
  logic [31:0]     r_wdata;
  logic [3:0]      r_be;
  logic            r_err;

  logic [31:0]     w_addr;
  logic [31:0]     w_wdata;
  logic [3:0]      w_be;
  logic            w_bad_f3;
  logic            w_misaligned;
  logic            w_fault;
  logic            w_timeout;

  assign w_addr    = in1 + {{20{imm[11]}}, imm};
  assign w_timeout = (r_cnt == CW'(TIMEOUT - 1));

  always_comb begin
    w_wdata      = in2;
    w_be         = 4'b0000;
    w_bad_f3     = 1'b0;
    w_misaligned = 1'b0;
    case (funct3)
      3'd0: begin
        w_wdata = {4{in2[7:0]}};
        w_be    = 4'b0001 << w_addr[1:0];
      end
      3'd1: begin
        w_wdata      = {2{in2[15:0]}};
        w_be         = 4'b0011 << w_addr[1:0];
        w_misaligned = w_addr[0];
      end
      3'd2: begin
        w_wdata      = in2;
        w_be         = 4'b1111;
        w_misaligned = |w_addr[1:0];
      end
      default: w_bad_f3 = 1'b1;
    endcase
  end

  assign w_fault = (opcode != OP_STORE) | w_bad_f3 | w_misaligned;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_IDLE;
    else        r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      ST_IDLE: if (start) w_next = w_fault ? ST_RESP : ST_REQ;
      ST_REQ:  if (d_ack || w_timeout) w_next = ST_RESP;
      ST_RESP: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
  end

  always_comb begin
    busy      = (r_state != ST_IDLE);
    d_we      = (r_state == ST_REQ);
    done      = (r_state == ST_RESP);
    err       = (r_state == ST_RESP) & r_err;
    d_addr    = r_addr;
    d_wdata   = r_wdata;
    d_be      = r_be;
    dbg_state = r_state;
  end

  // Access fields are captured once at issue so the bus stays stable during REQ.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_cnt   <= '0;
      r_addr  <= '0;
      r_wdata <= '0;
      r_be    <= '0;
      r_err   <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_cnt   <= '0;
            r_addr  <= w_addr;
            r_wdata <= w_wdata;
            r_be    <= w_fault ? 4'b0000 : w_be;
            r_err   <= w_fault;
          end
        end
        ST_REQ: begin
          if (d_ack) begin
            r_err <= 1'b0;
          end else if (w_timeout) begin
            r_err <= 1'b1;
            r_be  <= 4'b0000;
          end else begin
            r_cnt <= r_cnt + 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
